// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-address width, architectural
// register count and the register-address type.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_busy_table.sv
// Pending-write bitmap for the register scoreboard.
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : clear every busy bit next cycle (overrides set/clear)
//   clr_en / clr_addr     : clear one bit (write-back)
//   set_en / set_addr     : set one bit (issue); set wins over clear on same addr
//   rd_a_addr / rd_b_addr : two read ports (source operands)
//   rd_a_busy / rd_b_busy : busy bit at the read addresses
//   busy_vec              : full bitmap, bit 0 always 0
module sb_busy_table
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  reg_addr_t           rd_a_addr,
  input  reg_addr_t           rd_b_addr,
  output logic                rd_a_busy,
  output logic                rd_b_busy,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    // x0 is never tracked.
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rd_a_busy = busy_q[rd_a_addr];
  assign rd_b_busy = busy_q[rd_b_addr];
  assign busy_vec  = busy_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency results. Marks a destination busy when
// a long op issues, releases it on write-back, and stalls decode on RAW/WAW
// hazards or when the outstanding-operation limit is reached.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   id_valid, id_rs1/2, id_rd, id_regwrite, id_long : decode instruction
//   wb_valid, wb_rd         : long-latency write-back
//   flush                   : abort all in-flight long ops
//   stall                   : combinational decode hold
//   busy_vec, outstanding, full, err : scoreboard status
// Build option: SCOREBOARD_WB_BYPASS_EN lets a same-cycle write-back release
// hazards and the full condition (value supplied by the WB forwarding path).
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REGS        = riscv_pkg::NUM_REGS,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  reg_addr_t           id_rs1,
  input  reg_addr_t           id_rs2,
  input  reg_addr_t           id_rd,
  input  logic                id_regwrite,
  input  logic                id_long,
  input  logic                wb_valid,
  input  reg_addr_t           wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    outstanding,
  output logic                full,
  output logic                err
);

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic Byp = 1'b1;
`else
  localparam logic Byp = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic rs1_busy, rs2_busy, rd_busy, wb_busy;
  logic wb_byp;
  logic hz_rs1, hz_rs2, hz_rd, hz_full;
  logic issue, release_op;

  sb_busy_table #(
    .NUM_REGS (NUM_REGS)
  ) u_busy_table (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .clr_en    (wb_valid && !flush),
    .clr_addr  (wb_rd),
    .set_en    (issue && !flush),
    .set_addr  (id_rd),
    .rd_a_addr (id_rs1),
    .rd_b_addr (id_rs2),
    .rd_a_busy (rs1_busy),
    .rd_b_busy (rs2_busy),
    .busy_vec  (busy_vec)
  );

  assign rd_busy = busy_vec[id_rd];
  assign wb_busy = busy_vec[wb_rd];
  assign wb_byp  = Byp && wb_valid;

  always_comb begin
    hz_rs1  = (id_rs1 != '0) && rs1_busy && !(wb_byp && (wb_rd == id_rs1));
    hz_rs2  = (id_rs2 != '0) && rs2_busy && !(wb_byp && (wb_rd == id_rs2));
    hz_rd   = (id_rd != '0) && rd_busy && !(wb_byp && (wb_rd == id_rd));
    hz_full = id_long && full && !wb_byp;
    stall   = id_valid && (hz_rs1 || hz_rs2 || (id_regwrite && hz_rd) || hz_full);
    issue   = id_valid && !stall && id_regwrite && id_long && (id_rd != '0);
  end

  // Bit 0 of the bitmap is never set, so wb_busy already excludes x0.
  assign release_op = wb_valid && wb_busy;

  // A bad write-back (not busy, or x0) contributes nothing to the count; an
  // issue in the same cycle still counts so the count tracks the bitmap.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (issue && !release_op) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end else if (!issue && release_op) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (wb_valid && (!wb_busy || (wb_rd == '0))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign outstanding = cnt_q;
  assign full        = (cnt_q == CntMax);
  assign err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_regwrite = 1'b0, id_long = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] busy_vec;
  logic [2:0]  outstanding;
  logic        full;
  logic        err;

  int checks = 0;
  int failures = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_long     (id_long),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .outstanding (outstanding),
    .full        (full),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic lng);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_regwrite = rw; id_long = lng;
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
    #1;
  endtask

  initial begin
    // Reset
    #12;
    rst = 1'b0;
    tick();
    check_eq("rst_busy", busy_vec, 32'h0);
    check_eq("rst_out", 32'(outstanding), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);

    // Long-op RAW on x5
    set_id(1, 0, 0, 5, 1, 1);
    check_eq("raw_issue_stall", 32'(stall), 32'd0);
    tick();
    check_eq("raw_busy", busy_vec, 32'h0000_0020);
    check_eq("raw_out", 32'(outstanding), 32'd1);
    set_id(1, 5, 0, 6, 1, 0);
    check_eq("raw_stall1", 32'(stall), 32'd1);
    tick();
    check_eq("raw_stall2", 32'(stall), 32'd1);
    set_wb(1, 5);
    check_eq("raw_wb_cycle", 32'(stall), Byp ? 32'd0 : 32'd1);
    tick();
    set_wb(0, 0);
    check_eq("raw_after_wb", 32'(stall), 32'd0);
    check_eq("raw_busy_clr", busy_vec, 32'h0);
    check_eq("raw_out_clr", 32'(outstanding), 32'd0);
    check_eq("raw_err", 32'(err), 32'd0);
    set_id(0, 0, 0, 0, 0, 0);

    // WAW and x0
    set_id(1, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 0, 0, 7, 1, 0);
    check_eq("waw_stall", 32'(stall), 32'd1);
    set_id(1, 0, 0, 0, 1, 1);
    check_eq("x0_stall", 32'(stall), 32'd0);
    tick();
    check_eq("x0_busy", busy_vec, 32'h0000_0080);
    check_eq("x0_out", 32'(outstanding), 32'd1);
    set_id(0, 0, 0, 0, 0, 0);
    set_wb(1, 7);
    tick();
    set_wb(0, 0);
    check_eq("waw_out_clr", 32'(outstanding), 32'd0);

    // Full: long ops to x1..x4
    for (int r = 1; r <= 4; r++) begin
      set_id(1, 0, 0, 5'(r), 1, 1);
      tick();
    end
    check_eq("full_out", 32'(outstanding), 32'd4);
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_busy", busy_vec, 32'h0000_001e);
    set_id(1, 0, 0, 9, 1, 1);
    check_eq("full_long_stall", 32'(stall), 32'd1);
    set_id(1, 0, 0, 9, 1, 0);
    check_eq("full_short_stall", 32'(stall), 32'd0);
    tick();
    check_eq("full_short_out", 32'(outstanding), 32'd4);
    set_id(0, 0, 0, 0, 0, 0);
    set_wb(1, 1);
    tick();
    set_wb(1, 2);
    tick();
    set_wb(0, 0);
    check_eq("rel_busy", busy_vec, 32'h0000_0018);
    check_eq("rel_out", 32'(outstanding), 32'd2);
    check_eq("rel_full", 32'(full), 32'd0);

    // Simultaneous write-back of x3 and long issue to x3
    set_id(1, 0, 0, 3, 1, 1);
    set_wb(1, 3);
    check_eq("sim_stall", 32'(stall), Byp ? 32'd0 : 32'd1);
    tick();
    set_wb(0, 0);
    if (!Byp) begin
      check_eq("sim_nb_busy", busy_vec, 32'h0000_0010);
      check_eq("sim_nb_out", 32'(outstanding), 32'd1);
      check_eq("sim_nb_stall", 32'(stall), 32'd0);
      tick();
    end
    check_eq("sim_busy", busy_vec, 32'h0000_0018);
    check_eq("sim_out", 32'(outstanding), 32'd2);
    check_eq("sim_err", 32'(err), 32'd0);

    // Flush with three outstanding, then stray write-back
    set_id(1, 0, 0, 8, 1, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0);
    check_eq("pre_flush_out", 32'(outstanding), 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_busy", busy_vec, 32'h0);
    check_eq("flush_out", 32'(outstanding), 32'd0);
    check_eq("flush_err", 32'(err), 32'd0);
    set_wb(1, 6);
    tick();
    set_wb(0, 0);
    check_eq("stray_wb_err", 32'(err), 32'd1);
    check_eq("stray_wb_out", 32'(outstanding), 32'd0);
    tick();
    tick();
    check_eq("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-cycle with x10 busy
    set_id(1, 0, 0, 10, 1, 1);
    tick();
    set_id(1, 10, 0, 11, 1, 0);
    check_eq("mid_busy", busy_vec, 32'h0000_0400);
    check_eq("mid_stall", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy_vec, 32'h0);
    check_eq("arst_stall", 32'(stall), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_out", 32'(outstanding), 32'd0);
    set_id(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    set_wb(1, 10);
    tick();
    set_wb(0, 0);
    check_eq("post_rst_wb_err", 32'(err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register scoreboard for long-latency results (loads, multi-cycle divide). It sits in decode, on the producer side of the operand-dependency interface that the EX-stage forwarding logic consumes. It marks a destination register busy when a long-latency instruction issues and releases it when that result writes back. Decode is stalled on RAW/WAW hazards against pending registers, and when the outstanding-operation limit is reached.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- MAX_OUTSTANDING, 4, maximum in-flight long-latency writes.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  5  source register addresses.
- id_rd  in  5  destination register address.
- id_regwrite  in  1  the instruction writes id_rd.
- id_long  in  1  the instruction is long-latency; its result arrives via wb_*.
- wb_valid  in  1  a long-latency result is written back this cycle.
- wb_rd  in  5  destination of that write-back.
- flush  in  1  synchronous abort of all in-flight long operations.
- stall  out  1  hold decode (combinational).
- busy_vec  out  NUM_REGS  pending-write bitmap; bit 0 is always 0.
- outstanding  out  CNT_W  count of in-flight long writes.
- full  out  1  outstanding == MAX_OUTSTANDING.
- err  out  1  sticky protocol error.

## Operation
- hz(r) = (r != 0) && busy_vec[r] && !(byp && wb_valid && wb_rd == r).
- byp = 1 only when SCOREBOARD_WB_BYPASS_EN is defined.
- stall = id_valid && (hz(id_rs1) || hz(id_rs2) || (id_regwrite && hz(id_rd)) || (id_long && full && !(byp && wb_valid))).
- issue = id_valid && !stall && id_regwrite && id_long && id_rd != 0.
- A stalled instruction never sets a busy bit.
- Next-state update order: clear busy[wb_rd] on wb_valid, then set busy[id_rd] on issue. Set wins when both target the same register.
- Counter update: outstanding += issue − (wb_valid && busy[wb_rd]). Simultaneous issue and release leaves the count unchanged.
- The counter never exceeds MAX_OUTSTANDING and never goes below 0.
- err is set, and the counter is left unchanged, when any of these occur:
  - wb_valid targets a register that is not busy.
  - wb_rd == 0.
- err clears only on rst.
- flush clears busy_vec and outstanding next cycle and overrides issue and wb in the same cycle. err is unaffected.

## Timing
- Reset: busy_vec=0, outstanding=0, full=0, err=0.
- stall depends on busy_vec in the same cycle (no register); there is no combinational path from stall back into the inputs.
- Issue in cycle N: busy_vec[rd]=1 is visible from N+1, so a dependent instruction stalls from N+1.
- Write-back in cycle M with bypass: a dependent instruction proceeds in M, and busy_vec[rd]=0 from M+1.
- Write-back in cycle M without bypass: the dependent instruction still stalls in M and proceeds in M+1.
- rst asserted mid-operation clears everything immediately. Any write-back that arrives after reset sets err.

## Configuration
- SCOREBOARD_WB_BYPASS_EN defined:
  - A same-cycle write-back releases RAW/WAW hazards and the full condition.
  - This relies on the WB forwarding path (the 2'b10 select) supplying the value.
- Not defined: byp=0, so release takes effect one cycle after write-back. This is the simpler timing with one extra stall cycle per dependency.

## Structure
- Shared package riscv_pkg holds REG_ADDR_W=5, NUM_REGS=32 and the reg_addr_t typedef.
- Sub-module sb_busy_table holds the busy bitmap, its set/clear/flush logic and the two read ports.
- Counter, hazard logic and err logic stay in reg_scoreboard.

## Test plan
- Long-op RAW: issue load rd=5 (id_long=1), next cycle id_rs1=5 → stall=1 each cycle until wb_valid/wb_rd=5.
  - Bypass on: stall=0 in the write-back cycle.
  - Bypass off: stall=0 the cycle after.
- WAW plus x0: with busy[7]=1, an instruction with id_rd=7, id_regwrite=1 → stall=1. An instruction with id_rd=0, id_long=1 → no stall, busy_vec unchanged, outstanding unchanged.
- Full: issue 4 long ops to rd=1..4 → outstanding=4, full=1.
  - A 5th long op to rd=9 → stall=1.
  - A short op with rd=9 and sources not busy → stall=0.
- Simultaneous events: busy[3]=1, wb_rd=3 together with issue of a long op to rd=3 → busy[3]=1 next cycle and outstanding unchanged.
- Flush and error: with 3 outstanding, pulse flush → busy_vec=0, outstanding=0 next cycle. A later wb_valid with wb_rd=6 → err=1, and it stays set until rst.
- Reset mid-operation: assert rst asynchronously between edges with busy[10]=1 → busy_vec=0, stall=0 immediately.
